// File: rtl/md5_msg_sched_pkg.sv
// Shared constants and state encoding for the MD5 message-schedule stage.
package md5_msg_sched_pkg;
  localparam int MD5_WORDS  = 16;
  localparam int MD5_ROUNDS = 64;
  localparam int ROUND_W    = 6;
  localparam int IDX_W      = 4;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/md5_msg_sched_if.sv
// Load-port and round-record handshake bundle between message source, schedule and round logic.
interface md5_msg_sched_if
  import md5_msg_sched_pkg::*;
#(
  parameter int WORD_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [ROUND_W-1:0] out_round;
  logic [WORD_W-1:0]  out_word;
  logic               out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_round, out_word, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_round, out_word, out_last
  );
endinterface

// File: rtl/md5_msg_sched_gcalc.sv
// MD5 message-word index g(i) for round i; all four forms are taken mod 16.
module md5_msg_sched_gcalc
  import md5_msg_sched_pkg::*;
(
  input  logic [ROUND_W-1:0] round_i,
  output logic [IDX_W-1:0]   g_o
);
  logic [IDX_W-1:0] i_lo;

  assign i_lo = round_i[IDX_W-1:0];

  // 4-bit arithmetic wraps, which is exactly the mod-16 reduction
  always_comb begin
    g_o = i_lo;
    case (round_i[ROUND_W-1:IDX_W])
      2'd0:    g_o = i_lo;
      2'd1:    g_o = i_lo * 4'd5 + 4'd1;
      2'd2:    g_o = i_lo * 4'd3 + 4'd5;
      default: g_o = i_lo * 4'd7;
    endcase
  end
endmodule

// File: rtl/md5_msg_sched.sv
// Buffers one 16-word MD5 block, then streams 64 {i, M[g(i)]} round records downstream.
module md5_msg_sched
  import md5_msg_sched_pkg::*;
#(
  parameter int WORD_W = 32
)(
  input  logic            clk,
  input  logic            reset,
  md5_msg_sched_if.slave  bus,
  output logic            busy
);
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   wcnt_q, wcnt_d;
  logic [ROUND_W-1:0] rcnt_q, rcnt_d;
  logic               out_valid_q, out_valid_d;
  logic [ROUND_W-1:0] out_round_q, out_round_d;
  logic [WORD_W-1:0]  out_word_q, out_word_d;
  logic               out_last_q, out_last_d;
  logic [WORD_W-1:0]  mem_q [MD5_WORDS];
  logic [IDX_W-1:0]   g;
  logic               load_fire;

  md5_msg_sched_gcalc u_gcalc (
    .round_i (rcnt_q),
    .g_o     (g)
  );

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    out_valid_d = out_valid_q;
    out_round_d = out_round_q;
    out_word_d  = out_word_q;
    out_last_d  = out_last_q;
    load_fire   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (bus.in_valid) begin
          load_fire = 1'b1;
          wcnt_d    = wcnt_q + 4'd1;
          if (wcnt_q == IDX_W'(MD5_WORDS - 1)) begin
            state_d = ST_RUN;
            rcnt_d  = '0;
            wcnt_d  = '0;
          end
        end
      end
      ST_RUN: begin
        // Output register refills whenever it is empty or being consumed
        if (!out_valid_q || bus.out_ready) begin
          out_word_d  = mem_q[g];
          out_round_d = rcnt_q;
          out_last_d  = (rcnt_q == ROUND_W'(MD5_ROUNDS - 1));
          out_valid_d = 1'b1;
          rcnt_d      = rcnt_q + 6'd1;
          if (rcnt_q == ROUND_W'(MD5_ROUNDS - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && bus.out_ready && out_last_q) begin
          out_valid_d = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_round_q <= '0;
      out_word_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      out_valid_q <= out_valid_d;
      out_round_q <= out_round_d;
      out_word_q  <= out_word_d;
      out_last_q  <= out_last_d;
    end
  end

  // Word store is intentionally not reset; a full load always precedes any read
  always_ff @(posedge clk) begin
    if (load_fire) mem_q[wcnt_q] <= bus.in_data;
  end

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_round = out_round_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
endmodule

// File: tb/tb_md5_msg_sched.sv
// Scoreboard bench for md5_msg_sched: directed block loads, backpressure, resets and drain stall.
module tb_md5_msg_sched;
  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  md5_msg_sched_if #(.WORD_W(32)) bus ();

  md5_msg_sched #(.WORD_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
  );

  typedef struct {
    int          rnd;
    logic [31:0] word;
    bit          last;
  } rec_t;

  rec_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] obs [64];
  int          hs_cyc [64];

  function automatic int gref(int i);
    if (i < 16)      return i;
    else if (i < 32) return (5 * i + 1) % 16;
    else if (i < 48) return (3 * i + 5) % 16;
    else             return (7 * i) % 16;
  endfunction

  task automatic chk(string nm, bit ok, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every presented record against the queue head; pop on handshake
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: got round=%0d word=%0h with nothing expected",
                 bus.out_round, bus.out_word);
      end else begin
        if (bus.out_round !== 6'(q[0].rnd) || bus.out_word !== q[0].word ||
            bus.out_last !== q[0].last) begin
          errors++;
          $display("FAIL record: got round=%0d word=%0h last=%0b expected round=%0d word=%0h last=%0b",
                   bus.out_round, bus.out_word, bus.out_last, q[0].rnd, q[0].word, q[0].last);
        end
        if (bus.out_ready) begin
          obs[bus.out_round]    = bus.out_word;
          hs_cyc[bus.out_round] = cyc;
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic push_block(logic [31:0] base);
    rec_t r;
    for (int i = 0; i < 64; i++) begin
      r.rnd  = i;
      r.word = base + 32'(gref(i));
      r.last = (i == 63);
      q.push_back(r);
    end
  endtask

  task automatic load_word(logic [31:0] d, output int acc);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 400) begin
        errors++;
        $display("FAIL load_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
        $fatal(1, "load timeout");
      end
    end
    @(posedge clk);
    #1;
    acc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic load_block(logic [31:0] base, bit gap, output int first_acc, output int last_acc);
    int acc;
    first_acc = 0;
    for (int k = 0; k < 16; k++) begin
      load_word(base + 32'(k), acc);
      if (k == 0) first_acc = acc;
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
    last_acc = acc;
  endtask

  task automatic wait_round(int r);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
      if (t > 400) begin
        errors++;
        $display("FAIL round_timeout: round %0d never presented, required within 400 cycles", r);
        $fatal(1, "round timeout");
      end
    end while (!(bus.out_valid && bus.out_round == 6'(r)));
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (q.size() != 0) begin
      @(negedge clk);
      t++;
      if (t > 500) begin
        errors++;
        $display("FAIL drain_timeout: %0d records outstanding, required 0", q.size());
        $fatal(1, "drain timeout");
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic spot_checks(string tag);
    int          sp_i [7] = '{7, 16, 17, 32, 33, 48, 63};
    logic [31:0] sp_w [7] = '{32'd7, 32'd1, 32'd6, 32'd5, 32'd8, 32'd0, 32'd9};
    for (int s = 0; s < 7; s++)
      chk($sformatf("%s_spot_i%0d", tag, sp_i[s]), obs[sp_i[s]] === sp_w[s],
          64'(obs[sp_i[s]]), 64'(sp_w[s]));
  endtask

  task automatic idle_checks(string tag);
    chk({tag, "_out_valid"}, bus.out_valid === 1'b0, 64'(bus.out_valid), 64'd0);
    chk({tag, "_busy"},      busy === 1'b0,          64'(busy),          64'd0);
    chk({tag, "_in_ready"},  bus.in_ready === 1'b1,  64'(bus.in_ready),  64'd1);
  endtask

  initial begin
    int fa, la, fb, lb, hs63a;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    idle_checks("reset");
    chk("reset_out_round", bus.out_round === 6'd0,  64'(bus.out_round), 64'd0);
    chk("reset_out_word",  bus.out_word === 32'd0,  64'(bus.out_word),  64'd0);
    chk("reset_out_last",  bus.out_last === 1'b0,   64'(bus.out_last),  64'd0);
    reset = 1'b0;

    // Test 1: straight load, out_ready high
    foreach (obs[i]) obs[i] = 32'hDEAD_BEEF;
    push_block(32'h0);
    load_block(32'h0, 1'b0, fa, la);
    wait_empty();
    chk("t1_first_latency", hs_cyc[0] == la + 1, 64'(hs_cyc[0]), 64'(la + 1));
    chk("t1_back_to_back", hs_cyc[63] - hs_cyc[0] == 63, 64'(hs_cyc[63] - hs_cyc[0]), 64'd63);
    spot_checks("t1");

    // Test 2: 3-cycle backpressure at i=20
    push_block(32'h0);
    load_block(32'h0, 1'b0, fa, la);
    wait_round(20);
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold_round", bus.out_round === 6'd20, 64'(bus.out_round), 64'd20);
      chk("t2_hold_word",  bus.out_word === 32'd5,  64'(bus.out_word),  64'd5);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_empty();

    // Test 3: in_valid toggling every other cycle
    foreach (obs[i]) obs[i] = 32'hDEAD_BEEF;
    push_block(32'h0);
    load_block(32'h0, 1'b1, fa, la);
    wait_empty();
    spot_checks("t3");

    // Test 4: next block's in_valid held high through RUN/DRAIN
    push_block(32'h100);
    push_block(32'h200);
    load_block(32'h100, 1'b0, fa, la);
    load_block(32'h200, 1'b0, fb, lb);
    hs63a = hs_cyc[63];
    chk("t4_reload_timing", fb == hs63a + 2, 64'(fb), 64'(hs63a + 2));
    wait_empty();

    // Test 5: reset mid-run and mid-load
    push_block(32'h0);
    load_block(32'h0, 1'b0, fa, la);
    wait_round(40);
    reset = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_checks("t5_run_reset");
    for (int k = 0; k < 9; k++) load_word(32'h55 + 32'(k), fa);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_checks("t5_load_reset");
    push_block(32'h300);
    load_block(32'h300, 1'b0, fa, la);
    wait_empty();
    chk("t5_restart_latency", hs_cyc[0] == la + 1, 64'(hs_cyc[0]), 64'(la + 1));

    // Test 6: stall on the final record
    push_block(32'h400);
    load_block(32'h400, 1'b0, fa, la);
    wait_round(63);
    bus.out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t6_last_held", bus.out_last === 1'b1, 64'(bus.out_last), 64'd1);
      chk("t6_busy",      busy === 1'b1,         64'(busy),         64'd1);
      chk("t6_in_ready",  bus.in_ready === 1'b0, 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_empty();
    idle_checks("t6_after_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
